// File: rtl/arith_pkg.sv
// Shared arithmetic types and helpers for the pipelined add/subtract core.
package arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int slice_w(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple adder slice; also exposes the carry into its top bit.
module adder_slice
    import arith_pkg::*;
#(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out of the result.
    assign c_msb = sum[SW-1] ^ a[SW-1] ^ b[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one SW-bit slice resolved per stage, carry registered between stages.
module pipelined_adder
    import arith_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SW = slice_w(WIDTH, STAGES);

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    logic             vld_q   [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic             carry_q [STAGES];
    logic             cmsb_q  [STAGES];

    logic             vld_d   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic             carry_d [STAGES];
    logic             cmsb_d  [STAGES];

    logic adv;
    logic take;
    op_e  op;

    // A single enable freezes the whole pipe, bubbles included, so ordering never changes.
    assign adv      = ~vld_q[STAGES-1] | out_ready;
    assign in_ready = adv & ~reset;
    assign take     = in_valid & in_ready;
    assign op       = in_sub ? OP_SUB : OP_ADD;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] sum_src;
        logic [WIDTH-1:0] merged;
        logic             cin_src;
        logic [SW-1:0]    slice_sum;

        if (k == 0) begin : g_head
            assign a_src    = in_a;
            assign b_src    = (op == OP_SUB) ? ~in_b : in_b;
            assign cin_src  = (op == OP_SUB) ? 1'b1 : in_cin;
            assign sum_src  = '0;
            assign vld_d[k] = take;
        end else begin : g_body
            assign a_src    = a_q[k-1];
            assign b_src    = b_q[k-1];
            assign cin_src  = carry_q[k-1];
            assign sum_src  = sum_q[k-1];
            assign vld_d[k] = vld_q[k-1];
        end

        adder_slice #(.SW(SW)) u_slice (
            .a     (a_src[k*SW +: SW]),
            .b     (b_src[k*SW +: SW]),
            .cin   (cin_src),
            .sum   (slice_sum),
            .cout  (carry_d[k]),
            .c_msb (cmsb_d[k])
        );

        always_comb begin
            merged                = sum_src;
            merged[k*SW +: SW]    = slice_sum;
        end

        assign sum_d[k] = merged;
        assign a_d[k]   = a_src;
        assign b_d[k]   = b_src;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (reset) begin
                vld_q[k]   <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                carry_q[k] <= 1'b0;
                cmsb_q[k]  <= 1'b0;
            end else if (adv) begin
                vld_q[k]   <= vld_d[k];
                sum_q[k]   <= sum_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                carry_q[k] <= carry_d[k];
                cmsb_q[k]  <= cmsb_d[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = carry_q[STAGES-1];
    assign out_ovf   = cmsb_q[STAGES-1] ^ carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed scenarios on 64/4 plus random sweeps on 10/1, 10/5 and 64/64.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [63:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout, out_ovf;

    logic        sw_iv [3], sw_ir [3], sw_cin [3], sw_sub [3];
    logic        sw_ov [3], sw_ordy [3], sw_co [3], sw_of [3];
    logic [63:0] sw_a [3], sw_b [3], sw_sum [3];
    logic [9:0]  s0_sum, s1_sum;
    logic [63:0] s2_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(64), .STAGES(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    pipelined_adder #(.WIDTH(10), .STAGES(1)) u_sw0 (
        .clk(clk), .reset(reset), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]),
        .in_a(sw_a[0][9:0]), .in_b(sw_b[0][9:0]), .in_cin(sw_cin[0]), .in_sub(sw_sub[0]),
        .out_valid(sw_ov[0]), .out_ready(sw_ordy[0]), .out_sum(s0_sum),
        .out_cout(sw_co[0]), .out_ovf(sw_of[0])
    );

    pipelined_adder #(.WIDTH(10), .STAGES(5)) u_sw1 (
        .clk(clk), .reset(reset), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]),
        .in_a(sw_a[1][9:0]), .in_b(sw_b[1][9:0]), .in_cin(sw_cin[1]), .in_sub(sw_sub[1]),
        .out_valid(sw_ov[1]), .out_ready(sw_ordy[1]), .out_sum(s1_sum),
        .out_cout(sw_co[1]), .out_ovf(sw_of[1])
    );

    pipelined_adder #(.WIDTH(64), .STAGES(64)) u_sw2 (
        .clk(clk), .reset(reset), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]),
        .in_a(sw_a[2]), .in_b(sw_b[2]), .in_cin(sw_cin[2]), .in_sub(sw_sub[2]),
        .out_valid(sw_ov[2]), .out_ready(sw_ordy[2]), .out_sum(s2_sum),
        .out_cout(sw_co[2]), .out_ovf(sw_of[2])
    );

    assign sw_sum[0] = {54'd0, s0_sum};
    assign sw_sum[1] = {54'd0, s1_sum};
    assign sw_sum[2] = s2_sum;

    // Reference: {ovf, cout, sum} from plain integer arithmetic and the sign rule for overflow.
    function automatic logic [65:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic cin, input logic sub, input int w);
        logic [63:0] mask, bp, r;
        logic [64:0] full;
        logic        ci, ovf;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        bp   = sub ? (~b & mask) : (b & mask);
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, a & mask} + {1'b0, bp} + {64'd0, ci};
        r    = full[63:0] & mask;
        ovf  = (a[w-1] == bp[w-1]) && (r[w-1] != a[w-1]);
        return {ovf, full[w], r};
    endfunction

    task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input logic cin,
                             input logic sub, output int lat, output logic [63:0] sum,
                             output logic cout, output logic ovf);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0; sum = 'x; cout = 1'bx; ovf = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                sum = out_sum; cout = out_cout; ovf = out_ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1'b1; in_valid = 1'b1; in_a = 64'h1234; in_b = 64'h1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_sum !== 64'd0) begin errors++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        reset = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_beats_dropped got out_valid=%b want 0", seen); end
    endtask

    task automatic test_carry_chain();
        int lat; logic [63:0] s; logic c, o;
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, lat, s, c, o);
        checks++; if (lat != 4) begin errors++; $display("FAIL carry_latency got %0d want 4", lat); end
        checks++; if (s !== 64'd0) begin errors++; $display("FAIL carry_sum got %h want 0", s); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL carry_cout got %b want 1", c); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL carry_ovf got %b want 0", o); end
    endtask

    task automatic test_overflow();
        int lat; logic [63:0] s; logic c, o;
        send_beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat, s, c, o);
        checks++; if (s !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_pos_sum got %h want 8000000000000000", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL ovf_pos_cout got %b want 0", c); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_pos_ovf got %b want 1", o); end
        send_beat(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, lat, s, c, o);
        checks++; if (s !== 64'd0) begin errors++; $display("FAIL ovf_neg_sum got %h want 0", s); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL ovf_neg_cout got %b want 1", c); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_neg_ovf got %b want 1", o); end
    endtask

    task automatic test_subtract();
        int lat; logic [63:0] s; logic c, o;
        send_beat(64'd5, 64'd7, 1'b1, 1'b1, lat, s, c, o);
        checks++; if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_neg_sum got %h want fffffffffffffffe", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_neg_cout got %b want 0", c); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL sub_neg_ovf got %b want 0", o); end
        send_beat(64'd7, 64'd5, 1'b0, 1'b1, lat, s, c, o);
        checks++; if (s !== 64'd2) begin errors++; $display("FAIL sub_pos_sum got %h want 2", s); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL sub_pos_cout got %b want 1", c); end
    endtask

    task automatic test_back_to_back();
        int sent, recv, stall_left, cyc, first_acc, last_acc;
        logic [63:0] held;
        logic stall, seen;
        sent = 0; recv = 0; stall_left = 0; first_acc = -1; last_acc = -1; held = '0;
        in_cin = 1'b0; in_sub = 1'b0;
        for (cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            stall     = (stall_left > 0);
            out_ready = !stall;
            in_valid  = (sent < 8);
            in_a      = 64'(sent);
            in_b      = 64'(sent * 3);
            #1;
            if (stall) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
                if (stall_left == 3) begin
                    held = out_sum;
                    checks++; if (out_valid !== 1'b1 || out_sum !== 64'(4 * recv)) begin
                        errors++; $display("FAIL stall_first got v=%b sum=%h want v=1 sum=%h", out_valid, out_sum, 64'(4 * recv)); end
                end else begin
                    checks++; if (out_valid !== 1'b1 || out_sum !== held) begin
                        errors++; $display("FAIL stall_hold got v=%b sum=%h want v=1 sum=%h", out_valid, out_sum, held); end
                end
                stall_left--;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++; if (out_sum !== 64'(4 * recv)) begin
                    errors++; $display("FAIL b2b_sum[%0d] got %h want %h", recv, out_sum, 64'(4 * recv)); end
                recv++;
                if (recv == 2) stall_left = 3;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (sent != 8 || recv != 8) begin errors++; $display("FAIL b2b_count got sent=%0d recv=%0d want 8/8", sent, recv); end
        checks++; if (last_acc - first_acc != 10) begin
            errors++; $display("FAIL b2b_throughput got %0d cycles want 10", last_acc - first_acc); end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL b2b_duplicate got out_valid=%b want 0", seen); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] s; logic c, o, seen;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_cin = 1'b0; in_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a = 64'(100 + i); in_b = 64'd7;
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        seen = out_valid;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_stale got out_valid=%b want 0", seen); end
        send_beat(64'd1, 64'd1, 1'b0, 1'b0, lat, s, c, o);
        checks++; if (lat != 4) begin errors++; $display("FAIL midreset_latency got %0d want 4", lat); end
        checks++; if (s !== 64'd2) begin errors++; $display("FAIL midreset_sum got %h want 2", s); end
    endtask

    task automatic test_sweep(input int idx, input int w);
        logic [65:0] q[$];
        logic [65:0] exp_v, got_v;
        logic [63:0] mask;
        int got, cyc;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        got = 0; cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            sw_iv[idx]   = ($urandom_range(0, 3) != 0);
            sw_a[idx]    = {$urandom, $urandom} & mask;
            sw_b[idx]    = {$urandom, $urandom} & mask;
            sw_cin[idx]  = $urandom_range(0, 1) != 0;
            sw_sub[idx]  = $urandom_range(0, 1) != 0;
            sw_ordy[idx] = ($urandom_range(0, 3) != 0);
            #1;
            if (sw_ov[idx] && sw_ordy[idx]) begin
                got_v = {sw_of[idx], sw_co[idx], sw_sum[idx]};
                exp_v = (q.size() > 0) ? q.pop_front() : 'x;
                checks++; if (got_v !== exp_v) begin
                    errors++; $display("FAIL sweep%0d beat %0d got %h want %h", idx, got, got_v, exp_v); end
                got++;
            end
            if (sw_iv[idx] && sw_ir[idx])
                q.push_back(ref_model(sw_a[idx], sw_b[idx], sw_cin[idx], sw_sub[idx], w));
            cyc++;
        end
        sw_iv[idx] = 1'b0; sw_ordy[idx] = 1'b1;
        if (got < 1000) begin
            checks++; errors++;
            $display("FAIL sweep%0d_timeout got %0d results want 1000", idx, got);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sw_iv[i] = 1'b0; sw_ordy[i] = 1'b1; sw_a[i] = '0; sw_b[i] = '0;
            sw_cin[i] = 1'b0; sw_sub[i] = 1'b0;
        end
        test_reset();
        test_carry_chain();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_mid();
        test_sweep(0, 10);
        test_sweep(1, 10);
        test_sweep(2, 64);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
